// File: rtl/anim_scheduler_if.sv
// Push-button levels in, frame-step enable / pattern index / speed / mode out.
// No valid/ready handshake: pb_* are raw asynchronous levels and every output is a registered level or one-cycle pulse.
interface anim_scheduler_if;
    logic [7:0] pb_sel;
    logic       pb_faster;
    logic       pb_slower;
    logic       pb_auto;
    logic       pb_pause;
    logic       frame_tick;
    logic [2:0] pat_sel;
    logic       pat_restart;
    logic [7:0] speed;
    logic [1:0] mode;

    modport master (
        output pb_sel, pb_faster, pb_slower, pb_auto, pb_pause,
        input  frame_tick, pat_sel, pat_restart, speed, mode
    );

    modport slave (
        input  pb_sel, pb_faster, pb_slower, pb_auto, pb_pause,
        output frame_tick, pat_sel, pat_restart, speed, mode
    );
endinterface

// File: rtl/anim_scheduler.sv
// Idle-animation sequencer: button conditioning, frame tick, speed, pattern select, MANUAL/AUTO/PAUSED.
// Define ANIM_SCHED_AUTO_EN to build the AUTO mode and its dwell counter.
module anim_scheduler #(
    parameter int NPAT     = 8,
    parameter int SPD_MAX  = 20,
    parameter int SPD_STEP = 2,
    parameter int SPD_RST  = 2,
    parameter int DWELL    = 64
) (
    input  logic            hz100,
    input  logic            reset,
    anim_scheduler_if.slave io
);
    typedef enum logic [1:0] {
        MANUAL = 2'b00,
        AUTO   = 2'b01,
        PAUSED = 2'b10
    } state_t;

    localparam logic [8:0] STEP9    = 9'(SPD_STEP);
    localparam logic [8:0] MAX9     = 9'(SPD_MAX);
    localparam logic [2:0] PAT_LAST = 3'(NPAT - 1);

    logic [11:0] raw, sync1, sync2, prev, rise;
    logic        faster_ev, slower_ev, auto_ev, pause_ev, auto_go;
    logic        spd_ev, sel_ev, tick_now, adv, restart_next;
    logic        saved_auto, saved_next;
    logic [2:0]  sel_idx, pat_sel, pat_next;
    logic [7:0]  cnt, speed, speed_next;
    logic [8:0]  sum9;
    logic        frame_tick, pat_restart;
    state_t      state, state_next;

    // Bit layout: [7:0] select, 8 faster, 9 slower, 10 auto, 11 pause.
    assign raw = {io.pb_pause, io.pb_auto, io.pb_slower, io.pb_faster, io.pb_sel};

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise      = sync2 & ~prev;
    assign faster_ev = rise[8];
    assign slower_ev = rise[9];
    assign auto_ev   = rise[10];
    assign pause_ev  = rise[11];

`ifdef ANIM_SCHED_AUTO_EN
    assign auto_go = auto_ev;
`else
    logic unused_auto;
    assign auto_go     = 1'b0;
    assign unused_auto = auto_ev;
`endif

    // Pressing faster and slower together cancels both.
    assign spd_ev   = faster_ev ^ slower_ev;
    assign sel_ev   = (|rise[7:0]) && $onehot(sync2[7:0]);
    assign tick_now = (state != PAUSED) && !spd_ev && (cnt == speed);

    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (sync2[i]) sel_idx = i[2:0];
        end
    end

    always_comb begin
        speed_next = speed;
        sum9       = {1'b0, speed} + STEP9;
        if (faster_ev && !slower_ev) begin
            speed_next = ({1'b0, speed} >= STEP9) ? (speed - STEP9[7:0]) : 8'd0;
        end else if (slower_ev && !faster_ev) begin
            speed_next = (sum9 > MAX9) ? MAX9[7:0] : sum9[7:0];
        end
    end

    // Pause outranks auto when both arrive together.
    always_comb begin
        state_next = state;
        saved_next = saved_auto;
        case (state)
            MANUAL: begin
                if (pause_ev) begin
                    state_next = PAUSED;
                    saved_next = 1'b0;
                end else if (auto_go) begin
                    state_next = AUTO;
                end
            end
            AUTO: begin
                if (pause_ev) begin
                    state_next = PAUSED;
                    saved_next = 1'b1;
                end else if (auto_go) begin
                    state_next = MANUAL;
                end
            end
            PAUSED: begin
                if (pause_ev) state_next = saved_auto ? AUTO : MANUAL;
            end
            default: state_next = MANUAL;
        endcase
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            state      <= MANUAL;
            saved_auto <= 1'b0;
        end else begin
            state      <= state_next;
            saved_auto <= saved_next;
        end
    end

`ifdef ANIM_SCHED_AUTO_EN
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    logic [DW-1:0] dwell, dwell_next;

    // Dwell only counts ticks issued while already in AUTO; any exit or manual select restarts it.
    always_comb begin
        dwell_next = dwell;
        adv        = 1'b0;
        if (state == AUTO && tick_now) begin
            if (dwell == DWELL_LAST) begin
                adv        = 1'b1;
                dwell_next = '0;
            end else begin
                dwell_next = dwell + 1'b1;
            end
        end
        if (state_next != AUTO || sel_ev) dwell_next = '0;
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) dwell <= '0;
        else        dwell <= dwell_next;
    end
`else
    assign adv = 1'b0;
`endif

    always_comb begin
        pat_next     = pat_sel;
        restart_next = 1'b0;
        if (sel_ev) begin
            pat_next     = sel_idx;
            restart_next = 1'b1;
        end else if (adv) begin
            pat_next     = (pat_sel == PAT_LAST) ? 3'd0 : pat_sel + 3'd1;
            restart_next = 1'b1;
        end
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            cnt         <= 8'd0;
            speed       <= 8'(SPD_RST);
            pat_sel     <= 3'd0;
            frame_tick  <= 1'b0;
            pat_restart <= 1'b0;
        end else begin
            speed       <= speed_next;
            pat_sel     <= pat_next;
            frame_tick  <= tick_now;
            pat_restart <= restart_next;
            if (state != PAUSED) cnt <= (spd_ev || tick_now) ? 8'd0 : cnt + 8'd1;
        end
    end

    assign io.frame_tick  = frame_tick;
    assign io.pat_sel     = pat_sel;
    assign io.pat_restart = pat_restart;
    assign io.speed       = speed;
    assign io.mode        = state;
endmodule

// File: doc/anim_scheduler.md
# anim_scheduler

Sequencing controller for the idle-animation display. Converts raw push-button levels into a single-clock frame-step enable, a selected pattern index and a speed setting, so the pattern ring counters advance on `frame_tick` instead of divided clocks. It sits between the `pb` bus and the pattern generators and output multiplexer in `top`. It provides manual pattern selection, auto-cycling through patterns, pause, and saturating speed control.

## Interface
Parameters:
- `NPAT`, 8: number of patterns; `pat_sel` wraps modulo `NPAT`.
- `SPD_MAX`, 20: largest allowed `speed`.
- `SPD_STEP`, 2: `speed` change per button press.
- `SPD_RST`, 2: `speed` after reset.
- `DWELL`, 64: frame ticks per pattern in AUTO mode.

Ports:
- `hz100`  in  1: the single clock; all flops use its rising edge.
- `reset`  in  1: asynchronous, active-low; asserting it (low) clears all state immediately.
- `pb_sel`  in  8: pattern select buttons, raw and asynchronous.
- `pb_faster`  in  1: shortens the frame period.
- `pb_slower`  in  1: lengthens the frame period.
- `pb_auto`  in  1: toggles MANUAL/AUTO.
- `pb_pause`  in  1: toggles pause.
- `frame_tick`  out  1: registered, one-cycle step enable for the pattern generators.
- `pat_sel`  out  3: current pattern index.
- `pat_restart`  out  1: one-cycle pulse; pattern generators clear on it.
- `speed`  out  8: current frame period minus 1, in cycles.
- `mode`  out  2: 00 MANUAL, 01 AUTO, 10 PAUSED.

## Operation
- **Button conditioning.** Every button input passes through a 2-flop synchronizer followed by a previous-value flop.
  - A press event is the rising edge of the synchronized level.
  - Levels held high generate no further events.
- **Frame counter `cnt`** (8 bits), evaluated at each edge using the current state:
  - If the state is PAUSED, `cnt` holds and `frame_tick` is 0.
  - Else if a speed event occurs this cycle, `cnt` is set to 0 and `frame_tick` is 0.
  - Else if `cnt == speed`, `cnt` is set to 0 and `frame_tick` is 1.
  - Otherwise `cnt` increments and `frame_tick` is 0.
  - The tick period is therefore `speed`+1 cycles; `speed`=0 gives a tick every cycle.
- **Speed control.**
  - A `pb_faster` event sets `speed` to max(`speed`−`SPD_STEP`, 0).
  - A `pb_slower` event sets `speed` to min(`speed`+`SPD_STEP`, `SPD_MAX`).
  - Both events in the same cycle: both are ignored, `speed` and `cnt` are unchanged.
  - Speed events are honoured in every mode.
- **Pattern select.**
  - The select acts when the `pb_sel` rising-edge vector is nonzero and the synchronized `pb_sel` level is exactly one-hot. Then `pat_sel` is set to the index of the set bit, `pat_restart` is 1 for that cycle, and the dwell counter clears.
  - A multi-hot level is ignored.
  - The select is honoured in every mode and does not change `mode`.
- **State machine.**
  - MANUAL: a `pb_auto` event goes to AUTO; a `pb_pause` event goes to PAUSED, saving MANUAL.
  - AUTO: a `pb_auto` event goes to MANUAL; a `pb_pause` event goes to PAUSED, saving AUTO.
  - PAUSED: a `pb_pause` event returns to the saved mode; `pb_auto` is ignored.
  - `pb_pause` and `pb_auto` events in the same cycle: pause wins and `pb_auto` is discarded.
- **AUTO advance.**
  - The dwell counter (`$clog2(DWELL)` bits) counts `frame_tick`s.
  - On a tick with dwell == `DWELL`−1: `pat_sel` goes to (`pat_sel`+1) mod `NPAT`, dwell clears, and `pat_restart` pulses. With the default `NPAT`, index 7 wraps to 0.
  - A manual select in the same cycle wins: `pat_sel` takes the selected index and `pat_restart` pulses once.
  - Leaving AUTO clears dwell.
- **Reset values.**
  - Outputs: `frame_tick`=0, `pat_restart`=0, `pat_sel`=0, `speed`=`SPD_RST`, `mode`=00.
  - Internal state: `cnt`=0, dwell=0, saved mode=MANUAL, all synchronizer and previous-value flops 0.
  - Reset asserted mid-operation returns everything to these values asynchronously. Any pending or partially synchronized presses are discarded.

## Timing
- **Button-to-action latency.** A button that is low and is first sampled high at edge k has its effect on `pat_sel`, `speed` and `mode` at edge k+2.
- **Output timing.**
  - `pat_restart` is registered and coincides with the `pat_sel` update cycle.
  - `frame_tick` is registered and is high exactly one cycle per period.
- **First tick after reset.** The first tick occurs at the `SPD_RST`+1-th edge after reset deasserts (edge 3 with defaults).
- **Pause timing.**
  - A tick due in the cycle a pause event is processed is still issued, because the decision uses the current state.
  - After unpause, counting resumes from the held `cnt`.
- **AUTO dwell length.** AUTO advance occurs on the `DWELL`-th tick after entering AUTO or after the last restart.

## Configuration
- `ANIM_SCHED_AUTO_EN` defined:
  - AUTO state, `pb_auto` handling and the dwell counter are compiled in.
- `ANIM_SCHED_AUTO_EN` undefined:
  - No dwell counter is built and `pb_auto` is ignored.
  - `mode` only ever reads 00 or 10.
  - PAUSED always returns to MANUAL.
  - All other behaviour is identical.

## Test plan
- **Reset and free-run.** Reset low for 3 cycles, then release with no buttons pressed → `speed`=2, `mode`=00, `pat_sel`=0, and `frame_tick` high every 3rd cycle starting at edge 3.
- **Speed saturation.**
  - 12 `pb_slower` presses → `speed` steps 4, 6, …, 20 and then stays at 20; tick period is 21.
  - 12 `pb_faster` presses → `speed` reaches 0 and `frame_tick` is held high every cycle.
  - `pb_faster` and `pb_slower` pressed together → no change.
- **Select.**
  - `pb_sel`=0x08 → `pat_sel`=3 and a single `pat_restart` pulse, 2 cycles after sampling.
  - `pb_sel`=0x0C → ignored.
  - Holding `pb_sel`=0x08 → exactly one pulse.
- **AUTO (macro defined).**
  - `DWELL`=4, `speed`=0, `pb_auto` pressed → `pat_sel` advances every 4 ticks, 0→1→…→7→0, with `pat_restart` pulsing on each advance.
  - A select coinciding with an advance → the select value wins, with one pulse.
- **Pause.**
  - `pb_pause` in AUTO → `mode`=10, no ticks, `cnt` frozen.
  - `pb_auto` while paused → ignored.
  - `pb_pause` again → `mode`=01 and ticks resume with the phase preserved.
- **Reset mid-operation.** In AUTO at `speed`=14 with dwell mid-count, pull reset low → all outputs at their reset values immediately, before the next clock edge.
